// File: rtl/m31_mix_layer_pipe.sv
// m31_mix_layer_pipe
//   Two-stage pipelined M31 (P = 2^31-1) linear mix layer for the Poseidon2
//   round datapath, placed between the S-box layer and the next round-constant
//   add. Each transaction carries its own mode:
//     0 EXTERNAL     : out[i] = in[i] + sum of in[j] with j%GROUP == i%GROUP
//     1 INTERNAL_SUM : out[i] = in[i] + sum of all in[j]
//     2/3 BYPASS     : out[i] = in[i] (passed through bit-exact)
//   Stage 1 registers the state, the mode and the per-class / total sums.
//   Stage 2 applies the final add and drives the outputs straight from flops.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset (clears control and data)
//   in_valid_i   input transaction valid
//   in_ready_o   block can accept an input this cycle
//   mode_i       per-transaction mix mode
//   state_i      WIDTH packed 31-bit elements, element i at [i*31 +: 31]
//   out_valid_o  output transaction valid
//   out_ready_i  downstream accepts the output
//   state_o      mixed state, same packing as state_i
//   busy_o       either stage holds a transaction
module m31_mix_layer_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           mode_i,
  input  logic [WIDTH*31-1:0]  state_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH*31-1:0]  state_o,
  output logic                 busy_o
);

  if (WIDTH % GROUP != 0) begin : g_width_chk
    $error("m31_mix_layer_pipe: WIDTH must be a multiple of GROUP");
  end

  localparam logic [30:0] P        = 31'h7FFF_FFFF;
  localparam logic [1:0]  MODE_EXT = 2'd0;
  localparam logic [1:0]  MODE_INT = 2'd1;

  // Modular add for operands in [0, P]. The 32-bit sum is folded once
  // (2^31 == 1 mod P); the fold can land exactly on P, which maps to 0.
  // Operands of P (non-canonical zero) therefore still give canonical results.
  function automatic logic [30:0] m31_add(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] s;
    logic [30:0] f;
    s = {1'b0, a} + {1'b0, b};
    f = s[30:0] + {30'b0, s[31]};
    m31_add = (f == P) ? 31'd0 : f;
  endfunction

  logic              vld_p1, vld_p2;
  logic [1:0]        mode_p1;
  logic [WIDTH*31-1:0] state_p1, state_p2;
  logic [30:0]       sums_p1 [GROUP];
  logic [30:0]       total_p1;

  logic              s2_adv, accept;
  logic [30:0]       sums_d [GROUP];
  logic [30:0]       total_d;
  logic [WIDTH*31-1:0] mix_d;

  assign s2_adv      = vld_p1 && (!vld_p2 || out_ready_i);
  assign in_ready_o  = !vld_p1 || s2_adv;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = vld_p2;
  assign state_o     = state_p2;
  assign busy_o      = vld_p1 | vld_p2;

  // Stage 0 -> 1: residue-class sums and total folded in index order
  always_comb begin
    total_d = '0;
    for (int k = 0; k < GROUP; k++) begin
      sums_d[k] = '0;
    end
    for (int k = 0; k < GROUP; k++) begin
      for (int j = k; j < WIDTH; j += GROUP) begin
        sums_d[k] = m31_add(sums_d[k], state_i[j*31 +: 31]);
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      total_d = m31_add(total_d, state_i[j*31 +: 31]);
    end
  end

  // Stage 1 -> 2: per-element final add selected by the travelling mode
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode_p1)
        MODE_EXT: mix_d[i*31 +: 31] = m31_add(state_p1[i*31 +: 31], sums_p1[i % GROUP]);
        MODE_INT: mix_d[i*31 +: 31] = m31_add(state_p1[i*31 +: 31], total_p1);
        default:  mix_d[i*31 +: 31] = state_p1[i*31 +: 31];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (accept) begin
        vld_p1 <= 1'b1;
      end else if (s2_adv) begin
        vld_p1 <= 1'b0;
      end
      if (s2_adv) begin
        vld_p2 <= 1'b1;
      end else if (out_ready_i) begin
        vld_p2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_p1  <= '0;
      state_p1 <= '0;
      sums_p1  <= '{default: '0};
      total_p1 <= '0;
      state_p2 <= '0;
    end else begin
      if (accept) begin
        mode_p1  <= mode_i;
        state_p1 <= state_i;
        sums_p1  <= sums_d;
        total_p1 <= total_d;
      end
      if (s2_adv) begin
        state_p2 <= mix_d;
      end
    end
  end

endmodule

// File: tb/tb_m31_mix_layer_pipe.sv
// Testbench for m31_mix_layer_pipe: three instances (8/2, 16/4, 24/4) share
// one handshake and the low lanes of one 24-lane stimulus vector; each has its
// own expected-result queue fed from a modular-arithmetic reference model.
module tb_m31_mix_layer_pipe;

  localparam longint unsigned P64 = 64'h7FFF_FFFF;
  localparam logic [30:0]     P   = 31'h7FFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [743:0] st_in = '0;

  logic         in_ready8, in_ready16, in_ready24;
  logic         out_valid8, out_valid16, out_valid24;
  logic         busy8, busy16, busy24;
  logic [247:0] so8;
  logic [495:0] so16;
  logic [743:0] so24;

  int checks = 0;
  int failures = 0;
  bit rand_rdy = 1'b0;

  logic [743:0] q8[$];
  logic [743:0] q16[$];
  logic [743:0] q24[$];
  bit           stall[3];
  logic [743:0] held[3];

  always #5 clk = ~clk;

  m31_mix_layer_pipe #(.WIDTH(8), .GROUP(2)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready8),
    .mode_i(mode), .state_i(st_in[247:0]), .out_valid_o(out_valid8),
    .out_ready_i(out_ready), .state_o(so8), .busy_o(busy8));

  m31_mix_layer_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready16),
    .mode_i(mode), .state_i(st_in[495:0]), .out_valid_o(out_valid16),
    .out_ready_i(out_ready), .state_o(so16), .busy_o(busy16));

  m31_mix_layer_pipe #(.WIDTH(24), .GROUP(4)) dut24 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready24),
    .mode_i(mode), .state_i(st_in), .out_valid_o(out_valid24),
    .out_ready_i(out_ready), .state_o(so24), .busy_o(busy24));

  // Reference: plain integer sums reduced mod P; bypass copies raw lanes.
  function automatic logic [743:0] model(input logic [1:0] m, input logic [743:0] st,
                                         input int w, input int g);
    longint unsigned x[24];
    longint unsigned acc;
    logic [743:0]    r;
    r = '0;
    for (int i = 0; i < 24; i++) x[i] = 0;
    for (int i = 0; i < w; i++) x[i] = {33'd0, st[i*31 +: 31]};
    for (int i = 0; i < w; i++) begin
      if (m == 2'd0) begin
        acc = x[i];
        for (int j = 0; j < w; j++) if (j % g == i % g) acc += x[j];
        r[i*31 +: 31] = 31'(acc % P64);
      end else if (m == 2'd1) begin
        acc = x[i];
        for (int j = 0; j < w; j++) acc += x[j];
        r[i*31 +: 31] = 31'(acc % P64);
      end else begin
        r[i*31 +: 31] = x[i][30:0];
      end
    end
    return r;
  endfunction

  function automatic logic [743:0] fill(input logic [30:0] v);
    logic [743:0] r;
    for (int i = 0; i < 24; i++) r[i*31 +: 31] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [743:0] act, input logic [743:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_one(input int idx, input logic ov, input logic [743:0] so);
    logic [743:0] exp;
    bit have;
    have = 1'b0;
    exp = '0;
    if (stall[idx]) begin
      checks++;
      if (!ov || so !== held[idx]) begin
        failures++;
        $display("FAIL hold_stable[%0d]: valid=%0b state=%h expected valid=1 state=%h",
                 idx, ov, so, held[idx]);
      end
    end
    if (ov && out_ready) begin
      case (idx)
        0: if (q8.size() > 0)  begin exp = q8.pop_front();  have = 1'b1; end
        1: if (q16.size() > 0) begin exp = q16.pop_front(); have = 1'b1; end
        default: if (q24.size() > 0) begin exp = q24.pop_front(); have = 1'b1; end
      endcase
      checks++;
      if (!have) begin
        failures++;
        $display("FAIL unexpected_output[%0d]: got %h expected no output", idx, so);
      end else if (so !== exp) begin
        failures++;
        $display("FAIL result[%0d]: got %h expected %h", idx, so, exp);
      end
    end
    stall[idx] = ov && !out_ready;
    held[idx]  = so;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_one(0, out_valid8,  {496'd0, so8});
      mon_one(1, out_valid16, {248'd0, so16});
      mon_one(2, out_valid24, so24);
    end else begin
      for (int i = 0; i < 3; i++) stall[i] = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one transaction and hold it until accepted; returns 1 time unit
  // after the accepting edge with in_valid deasserted.
  task automatic send(input logic [1:0] m, input logic [743:0] st);
    int t;
    t = 0;
    mode = m;
    st_in = st;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready16 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready16) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=0 expected 1 within 200 cycles");
    end else begin
      q8.push_back(model(m, st, 8, 2));
      q16.push_back(model(m, st, 16, 4));
      q24.push_back(model(m, st, 24, 4));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q8.size() + q16.size() + q24.size()) != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      failures++;
      $display("FAIL drain_timeout: queued=%0d expected 0", q16.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [743:0] rand_state();
    logic [743:0] r;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 9))
        0:       r[i*31 +: 31] = P;
        1:       r[i*31 +: 31] = P - 31'd1;
        2:       r[i*31 +: 31] = 31'd0;
        default: r[i*31 +: 31] = 31'($urandom);
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [743:0] v;
    logic [743:0] e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {743'd0, out_valid16}, '0);
    check("reset_state_o", {248'd0, so16}, '0);
    check("reset_busy", {743'd0, busy16}, '0);
    check("reset_in_ready", {743'd0, in_ready16}, {743'd0, 1'b1});
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // EXTERNAL, all ones, with latency check
    send(2'd0, fill(31'd1));
    check("lat_not_early", {743'd0, out_valid16}, '0);
    @(posedge clk);
    #1;
    check("lat_valid", {743'd0, out_valid16}, {743'd0, 1'b1});
    check("ext_ones", {248'd0, so16}, {248'd0, fill(31'd5)[495:0]});
    drain();

    // INTERNAL_SUM, all ones and ramp
    send(2'd1, fill(31'd1));
    @(posedge clk);
    #1;
    check("int_ones", {248'd0, so16}, {248'd0, fill(31'd17)[495:0]});
    drain();
    for (int i = 0; i < 24; i++) begin
      v[i*31 +: 31] = 31'(i);
      e[i*31 +: 31] = (i < 16) ? 31'(i + 120) : 31'd0;
    end
    send(2'd1, v);
    @(posedge clk);
    #1;
    check("int_ramp", {248'd0, so16}, e);
    drain();

    // Wrap cases and non-canonical P
    send(2'd0, fill(P - 31'd1));
    @(posedge clk);
    #1;
    check("ext_wrap", {248'd0, so16}, {248'd0, fill(31'h7FFF_FFFA)[495:0]});
    drain();
    v = '0;
    v[30:0] = P;
    send(2'd0, v);
    @(posedge clk);
    #1;
    check("ext_p_is_zero", {248'd0, so16}, '0);
    drain();
    send(2'd2, v);
    @(posedge clk);
    #1;
    check("bypass_p_kept", {248'd0, so16}, v);
    drain();

    // Backpressure: five transactions, alternating modes, downstream stalled
    out_ready = 1'b0;
    send(2'd0, rand_state());
    send(2'd1, rand_state());
    check("bp_in_ready_low", {743'd0, in_ready16}, '0);
    check("bp_busy", {743'd0, busy16}, {743'd0, 1'b1});
    fork
      begin
        send(2'd2, rand_state());
        send(2'd0, rand_state());
        send(2'd1, rand_state());
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight
    out_ready = 1'b0;
    send(2'd0, rand_state());
    send(2'd1, rand_state());
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {743'd0, out_valid16}, '0);
    check("rst_state_o", {248'd0, so16}, '0);
    check("rst_busy", {741'd0, busy8, busy16, busy24}, '0);
    q8.delete();
    q16.delete();
    q24.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_output", {741'd0, out_valid8, out_valid16, out_valid24}, '0);
    end
    @(posedge clk);
    #1;

    // Randomised streaming with random valid gaps and random ready
    rand_rdy = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(2'($urandom_range(0, 3)), rand_state());
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("end_empty", {741'd0, busy8, busy16, busy24}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
